// File: rtl/dp_ram_be_init.sv
// Dual-port RAM (1W/1R, one clock) with byte enables, write-first collision forwarding and a post-reset zero sweep.
// Latency: read data and rd_valid one edge after read_en (two edges with RD_PIPE_EN); the sweep takes 2**ADDR_WIDTH edges.
// Backpressure: none; both ports are ignored until init_done, after which every request is accepted each cycle.
// Build option: `define RD_PIPE_EN adds an output register stage (read latency 2, same flags, same data).
module dp_ram_be_init #(
  parameter int  DATA_WIDTH = 128,
  parameter int  ADDR_WIDTH = 12,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BE_WIDTH-1:0]   wr_byte_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  collision,
  output logic                  init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Sweep FSM encoding
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

  // Storage; never reset directly, the sweep zeroes it instead
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Sweep state
  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready;

  // Shared write port (sweep or user)
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BE_WIDTH-1:0]   mem_be;
  logic [DATA_WIDTH-1:0] mem_wdat;

  // Read path
  logic                  rd_fire;
  logic                  same_addr;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_merge;

  // First output stage
  logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
  logic                  vld1_q, vld1_d;
  logic                  coll1_q, coll1_d;

  assign ready = (state_q == ST_READY);

  // Sweep FSM: walk every address once, then park in READY until reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == ADDR_LAST) begin
        state_d = ST_READY;
      end
    end
  end

  // Sweep FSM registers; reset restarts the sweep from address 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write port mux: the sweep owns the port until READY, user writes are dropped meanwhile
  always_comb begin
    mem_we   = write_en;
    mem_addr = wr_addr;
    mem_be   = wr_byte_en;
    mem_wdat = data_in;
    if (!ready) begin
      mem_we   = 1'b1;
      mem_addr = cnt_q;
      mem_be   = '1;
      mem_wdat = '0;
    end
  end

  // Byte-masked array write; a zero byte mask leaves the word untouched
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (mem_be[b]) begin
          mem[mem_addr][8*b +: 8] <= mem_wdat[8*b +: 8];
        end
      end
    end
  end

  assign rd_fire   = ready & read_en;
  assign same_addr = write_en & (wr_addr == rd_addr);
  assign rd_old    = mem[rd_addr];

  // Write-first forwarding: enabled bytes of a same-address write replace the stored bytes
  always_comb begin
    rd_merge = rd_old;
    if (same_addr) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (wr_byte_en[b]) begin
          rd_merge[8*b +: 8] = data_in[8*b +: 8];
        end
      end
    end
  end

  // First read stage: capture on a read, hold data otherwise; flags are per-edge pulses
  always_comb begin
    dout1_d = dout1_q;
    vld1_d  = rd_fire;
    coll1_d = rd_fire & same_addr;
    if (rd_fire) begin
      dout1_d = rd_merge;
    end
  end

  // First read stage registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout1_q <= '0;
      vld1_q  <= 1'b0;
      coll1_q <= 1'b0;
    end else begin
      dout1_q <= dout1_d;
      vld1_q  <= vld1_d;
      coll1_q <= coll1_d;
    end
  end

`ifdef RD_PIPE_EN
  // Optional second stage: delays data and both flags by one more edge
  logic [DATA_WIDTH-1:0] dout2_q, dout2_d;
  logic                  vld2_q, vld2_d;
  logic                  coll2_q, coll2_d;

  // Second stage loads only valid words so data_out still holds between reads
  always_comb begin
    dout2_d = dout2_q;
    vld2_d  = vld1_q;
    coll2_d = coll1_q;
    if (vld1_q) begin
      dout2_d = dout1_q;
    end
  end

  // Second stage registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout2_q <= '0;
      vld2_q  <= 1'b0;
      coll2_q <= 1'b0;
    end else begin
      dout2_q <= dout2_d;
      vld2_q  <= vld2_d;
      coll2_q <= coll2_d;
    end
  end

  assign data_out  = dout2_q;
  assign rd_valid  = vld2_q;
  assign collision = coll2_q;
`else
  assign data_out  = dout1_q;
  assign rd_valid  = vld1_q;
  assign collision = coll1_q;
`endif

  assign init_done = ready;

endmodule

// File: tb/tb_dp_ram_be_init.sv
// Directed bench for dp_ram_be_init: reset state, sweep length, sweep abort, byte enables, collisions, streaming reads.
module tb_dp_ram_be_init;

  localparam int DW = 128;
  localparam int AW = 12;
  localparam int BW = DW / 8;
`ifdef RD_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          write_en;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_byte_en;
  logic [DW-1:0] data_in;
  logic          read_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          collision;
  logic          init_done;

  dp_ram_be_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .write_en   (write_en),
    .wr_addr    (wr_addr),
    .wr_byte_en (wr_byte_en),
    .data_in    (data_in),
    .read_en    (read_en),
    .rd_addr    (rd_addr),
    .data_out   (data_out),
    .rd_valid   (rd_valid),
    .collision  (collision),
    .init_done  (init_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp_d;
    logic          exp_v;
    logic          exp_c;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [DW-1:0] W_DEAD  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [DW-1:0] W_ONES  = {DW{1'b1}};
  localparam logic [DW-1:0] W_HALF  = {{(DW/2){1'b1}}, {(DW/2){1'b0}}};
  localparam logic [DW-1:0] W_12FF  = 128'h12FF;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    write_en   = 1'b0;
    wr_addr    = '0;
    wr_byte_en = '0;
    data_in    = '0;
    read_en    = 1'b0;
    rd_addr    = '0;
  endtask

  function automatic logic [DW-1:0] seq_word(input int j);
    logic [DW-1:0] w;
    w = DW'(32'hA0 + j);
    return w;
  endfunction

  initial begin
    int done_at;
    int rv_seen;
    int j;
    logic [DW-1:0] exp_d;

    //          we    wa      be        wd      re    ra      exp_d   v     c
    vt[0]  = '{1'b0, 12'd0,  16'h0000, '0,     1'b1, 12'd5,  '0,     1'b1, 1'b0};
    vt[1]  = '{1'b0, 12'd0,  16'h0000, '0,     1'b1, 12'd50, '0,     1'b1, 1'b0};
    vt[2]  = '{1'b1, 12'd2,  16'hFFFF, W_DEAD, 1'b0, 12'd0,  '0,     1'b0, 1'b0};
    vt[3]  = '{1'b0, 12'd0,  16'h0000, '0,     1'b1, 12'd2,  W_DEAD, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 12'd7,  16'hFFFF, W_ONES, 1'b0, 12'd0,  W_DEAD, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 12'd7,  16'h00FF, '0,     1'b0, 12'd0,  W_DEAD, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 12'd0,  16'h0000, '0,     1'b1, 12'd7,  W_HALF, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 12'd9,  16'hFFFF, 128'h1234, 1'b1, 12'd9, 128'h1234, 1'b1, 1'b1};
    vt[8]  = '{1'b0, 12'd0,  16'h0000, '0,     1'b0, 12'd0,  128'h1234, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 12'd9,  16'h0001, W_ONES, 1'b1, 12'd9,  W_12FF, 1'b1, 1'b1};
    vt[10] = '{1'b1, 12'd11, 16'hFFFF, W_ONES, 1'b1, 12'd9,  W_12FF, 1'b1, 1'b0};
    vt[11] = '{1'b0, 12'd0,  16'h0000, '0,     1'b1, 12'd11, W_ONES, 1'b1, 1'b0};
    vt[12] = '{1'b1, 12'd9,  16'h0000, W_ONES, 1'b1, 12'd9,  W_12FF, 1'b1, 1'b1};
    vt[13] = '{1'b0, 12'd0,  16'h0000, '0,     1'b1, 12'd9,  W_12FF, 1'b1, 1'b0};

    idle();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_data_out",  data_out,  '0);
    chk("rst_rd_valid",  rd_valid,  1'b0);
    chk("rst_collision", collision, 1'b0);
    chk("rst_init_done", init_done, 1'b0);

    // Start a sweep, abort it after 100 edges with an asynchronous reset
    reset = 1'b1;
    repeat (100) step();
    chk("abort_pre_init_done", init_done, 1'b0);
    reset = 1'b0;
    #1;
    chk("abort_init_done", init_done, 1'b0);
    chk("abort_rd_valid",  rd_valid,  1'b0);
    step();
    step();
    reset = 1'b1;

    // Full sweep with traffic that must be ignored (address 50 is cleared early, so a leaked write would stick)
    write_en   = 1'b1;
    wr_addr    = 12'd50;
    wr_byte_en = '1;
    data_in    = W_ONES;
    read_en    = 1'b1;
    rd_addr    = 12'd50;
    done_at = 0;
    rv_seen = 0;
    for (int n = 1; n <= 5000; n++) begin
      step();
      if (rd_valid || collision) rv_seen++;
      if (init_done) begin
        done_at = n;
        break;
      end
    end
    idle();
    chk("sweep_edges", DW'(done_at), DW'(4096));
    chk("sweep_no_rd_valid", DW'(rv_seen), '0);

    // Table vectors: apply for one edge, idle out the remaining latency, compare
    for (int i = 0; i < NV; i++) begin
      write_en   = vt[i].we;
      wr_addr    = vt[i].wa;
      wr_byte_en = vt[i].be;
      data_in    = vt[i].wd;
      read_en    = vt[i].re;
      rd_addr    = vt[i].ra;
      step();
      idle();
      for (int k = 1; k < LAT; k++) step();
      chk($sformatf("vec%0d_data", i),      data_out,  vt[i].exp_d);
      chk($sformatf("vec%0d_valid", i),     rd_valid,  vt[i].exp_v);
      chk($sformatf("vec%0d_collision", i), collision, vt[i].exp_c);
    end

    // Back-to-back reads of addresses 1..3, then idle
    for (int a = 1; a <= 3; a++) begin
      write_en   = 1'b1;
      wr_addr    = AW'(a);
      wr_byte_en = '1;
      data_in    = seq_word(a);
      step();
    end
    idle();
    for (int k = 1; k < LAT; k++) step();
    for (int k = 1; k <= 5; k++) begin
      read_en = (k <= 3);
      rd_addr = (k <= 3) ? AW'(k) : '0;
      step();
      j = k - LAT + 1;
      if (j < 1)      exp_d = W_12FF;
      else if (j > 3) exp_d = seq_word(3);
      else            exp_d = seq_word(j);
      chk($sformatf("stream%0d_valid", k), rd_valid, (j >= 1 && j <= 3));
      chk($sformatf("stream%0d_data", k),  data_out, exp_d);
      chk($sformatf("stream%0d_collision", k), collision, 1'b0);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dp_ram_be_init.md
Name: dp_ram_be_init

Overview:
- Parametrised synchronous dual-port RAM: one write port, one read port, single clock.
- Successor to the fixed 4Kx128 RAM; width and depth are set by parameters.
- Adds per-byte write enables, write-first read/write collision forwarding, a read-valid flag and a hardware zero-initialisation sweep after reset.
- Sits between datapath producers and consumers as the standard on-chip buffer.

Parameters:
- DATA_WIDTH, 128, data word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 12, address width; depth is 2**ADDR_WIDTH words.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width; derived, never overridden.

Ports:
- clock  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- write_en  input  1  write request.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_byte_en  input  BE_WIDTH  bit i enables data_in[8i+7:8i].
- data_in  input  DATA_WIDTH  write data.
- read_en  input  1  read request.
- rd_addr  input  ADDR_WIDTH  read address.
- data_out  output  DATA_WIDTH  read data.
- rd_valid  output  1  data_out holds the result of a read issued one edge earlier.
- collision  output  1  the read being returned hit the same-cycle write address.
- init_done  output  1  zero sweep is complete; ports are accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - data_out=0, rd_valid=0, collision=0, init_done=0.
  - Sweep counter=0; FSM enters CLEAR.
  - Memory array is not reset directly; the sweep clears it.
- FSM CLEAR:
  - Each edge writes all-zero to address counter, then increments counter.
  - After the edge that writes address 2**ADDR_WIDTH-1, FSM enters READY and init_done=1.
  - The sweep takes exactly 2**ADDR_WIDTH edges after reset release.
  - write_en and read_en are ignored in CLEAR; rd_valid stays 0.
  - Reset asserted mid-sweep restarts the sweep at address 0.
- FSM READY:
  - Stays in READY until reset; init_done stays 1.
- Write (READY, write_en=1 at edge):
  - Bytes with wr_byte_en[i]=1 take data_in; other bytes keep their old value.
  - write_en=1 with wr_byte_en=0 is a legal no-op.
- Read (READY, read_en=1 at edge N):
  - data_out updates at edge N and rd_valid=1 after edge N (read latency 1).
  - At an edge with read_en=0, rd_valid goes 0 and data_out holds its last value.
  - Back-to-back reads give one word per cycle.
- Collision (read_en and write_en both 1, rd_addr==wr_addr, same edge):
  - Write-first: data_out = merge of enabled new bytes from data_in and old bytes from the array.
  - collision=1 for the same cycle as that rd_valid; otherwise collision=0.
  - Different addresses in the same cycle: independent, no interaction.
- Address range is always 2**ADDR_WIDTH words, so there are no out-of-range accesses and no wrap logic on the ports.

Optional Feature:
- Macro: RD_PIPE_EN.
- Defined: an extra output register stage; read latency is 2 edges, and rd_valid and collision are delayed identically. Collision data is still write-first, and the output stage resets to 0.
- Undefined: read latency is 1 edge, as above.

Test Plan:
- Reset release, then count edges -> init_done rises after exactly 4096 edges. Then read rd_addr=5 -> data_out=0, rd_valid=1 one edge later.
- After init: write wr_addr=2, data_in=128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, wr_byte_en=all ones; next cycle read rd_addr=2 -> data_out equals that word, rd_valid=1, collision=0.
- Write address 7 with all ones, then write address 7 with data_in=0 and wr_byte_en=16'h00FF; read address 7 -> data_out=128'hFFFF..FFFF_0000_0000_0000_0000 (upper 64 bits 1, lower 64 bits 0).
- Same edge: write address 9 with 128'h1234 (full enables) and read address 9 -> data_out=128'h1234, collision=1 for one cycle.
- Drive reset=0 at sweep count 100, release it, and issue read/write during CLEAR -> init_done=0 for a further 4096 edges, rd_valid stays 0, and the memory content written during CLEAR is still 0 after init.
- Reads to addresses 1, 2, 3 on consecutive edges, then idle -> three consecutive rd_valid cycles with correct data, then rd_valid=0 with data_out holding the address-3 data. Repeat with RD_PIPE_EN defined -> same results, shifted by one cycle.
